// File: rtl/regfile_wb_pkg.sv
// Shared types and helpers for the register file / writeback block.
package regfile_pkg;

   localparam int DEF_XLEN = 32;
   localparam int DEF_NREG = 32;
   localparam int ZERO_REG = 0;

   // Address width for an n-entry structure; never narrower than one bit.
   function automatic int addr_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   localparam int DEF_AW = addr_w(DEF_NREG);

   typedef struct packed {
      logic [DEF_XLEN-1:0] pc;
      logic [DEF_AW-1:0]   wnum;
      logic [DEF_XLEN-1:0] wdata;
   } trace_t;

endpackage

// File: rtl/regfile_wb_if.sv
// Core-side bus of the register file: read ports, ALU/load commit inputs, debug trace.
interface regfile_wb_if
   import regfile_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int NRD  = 3
) ();
   localparam int AW = addr_w(NREG);

   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic                alu_we;
   logic [AW-1:0]       alu_waddr;
   logic [XLEN-1:0]     alu_wdata;
   logic [XLEN-1:0]     alu_pc;
   logic                ld_issue;
   logic [AW-1:0]       ld_rt;
   logic [XLEN-1:0]     ld_pc;
   logic [XLEN-1:0]     mem_rdata;
   logic                ld_pending;
   logic [XLEN-1:0]     debug_wb_pc;
   logic                debug_wb_rf_wen;
   logic [AW-1:0]       debug_wb_rf_wnum;
   logic [XLEN-1:0]     debug_wb_rf_wdata;
   logic                trace_ovf;

   modport master (
      output rd_addr, alu_we, alu_waddr, alu_wdata, alu_pc,
             ld_issue, ld_rt, ld_pc, mem_rdata,
      input  rd_data, ld_pending, debug_wb_pc, debug_wb_rf_wen,
             debug_wb_rf_wnum, debug_wb_rf_wdata, trace_ovf
   );

   modport slave (
      input  rd_addr, alu_we, alu_waddr, alu_wdata, alu_pc,
             ld_issue, ld_rt, ld_pc, mem_rdata,
      output rd_data, ld_pending, debug_wb_pc, debug_wb_rf_wen,
             debug_wb_rf_wnum, debug_wb_rf_wdata, trace_ovf
   );

endinterface

// File: rtl/regfile_wb_trace_fifo.sv
// Commit-trace queue: two ordered pushes and one pop per cycle, with a bypass
// so an empty queue hands the oldest new commit straight to the output.
module trace_fifo
   import regfile_pkg::*;
#(
   parameter int  TDEPTH  = 4,
   parameter type entry_t = trace_t
) (
   input  logic   clk,
   input  logic   resetn,
   input  logic   push0_i,
   input  entry_t push0_data_i,
   input  logic   push1_i,
   input  entry_t push1_data_i,
   output logic   out_valid_o,
   output entry_t out_data_o,
   output logic   ovf_o
);
   localparam int PW = addr_w(TDEPTH);
   localparam int CW = $clog2(TDEPTH + 1);

   entry_t        mem_q [TDEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d, kept;
   logic          ovf_q, ovf_d;
   logic          pop, wr0, wr1;
   logic [1:0]    n_in, n_enq;
   entry_t        in_a, in_b, enq_a, enq_b;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(TDEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Order incoming commits, pick head or bypass, and decide which entries fit
   always_comb begin
      in_a = push0_data_i;
      in_b = push1_data_i;
      n_in = 2'd0;
      if (push0_i) begin
         n_in = push1_i ? 2'd2 : 2'd1;
      end else if (push1_i) begin
         in_a = push1_data_i;
         n_in = 2'd1;
      end
      pop         = (count_q != '0);
      out_valid_o = pop || (n_in != 2'd0);
      out_data_o  = pop ? mem_q[rd_ptr_q] : in_a;
      if (pop) begin
         enq_a = in_a;
         enq_b = in_b;
         n_enq = n_in;
      end else begin
         enq_a = in_b;
         enq_b = in_b;
         n_enq = (n_in == 2'd2) ? 2'd1 : 2'd0;
      end
      // the pop frees its slot before this cycle's pushes are placed
      kept     = count_q - CW'(pop);
      wr0      = (n_enq != 2'd0) && (kept < CW'(TDEPTH));
      wr1      = (n_enq == 2'd2) && (kept < CW'(TDEPTH - 1));
      ovf_d    = ovf_q || ((n_enq != 2'd0) && !wr0) || ((n_enq == 2'd2) && !wr1);
      count_d  = kept + CW'(wr0) + CW'(wr1);
      rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (wr1)      wr_ptr_d = ptr_inc(ptr_inc(wr_ptr_q));
      else if (wr0) wr_ptr_d = ptr_inc(wr_ptr_q);
   end

   // Entry storage
   always_ff @(posedge clk) begin
      if (resetn && wr0) mem_q[wr_ptr_q] <= enq_a;
      if (resetn && wr1) mem_q[ptr_inc(wr_ptr_q)] <= enq_b;
   end

   // Pointers, occupancy and sticky overflow
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   assign ovf_o = ovf_q;

endmodule

// File: rtl/regfile_wb.sv
// Architectural register file with delayed load writeback, load-return read
// bypass and an in-order commit trace.
module regfile_wb
   import regfile_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int NREG   = 32,
   parameter int NRD    = 3,
   parameter int TDEPTH = 4
) (
   input  logic        clk,
   input  logic        resetn,
   regfile_wb_if.slave bus
);
   localparam int AW = addr_w(NREG);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [AW-1:0]   wnum;
      logic [XLEN-1:0] wdata;
   } entry_t;

   logic [XLEN-1:0] regs_q [NREG];
   logic            ld_pending_q, ld_pending_d;
   logic [AW-1:0]   pend_rt_q, pend_rt_d;
   logic [XLEN-1:0] pend_pc_q, pend_pc_d;
   logic            alu_commit;
   entry_t          ld_entry, alu_entry, trace_head;
   logic            trace_valid;
   logic            dbg_wen_q;
   entry_t          dbg_q;

   assign alu_commit = bus.alu_we && (bus.alu_waddr != AW'(ZERO_REG));
   assign ld_entry   = {pend_pc_q, pend_rt_q, bus.mem_rdata};
   assign alu_entry  = {bus.alu_pc, bus.alu_waddr, bus.alu_wdata};

   // Arm the pending slot for a load to a real register; anything else clears it
   always_comb begin
      ld_pending_d = bus.ld_issue && (bus.ld_rt != AW'(ZERO_REG));
      pend_rt_d    = pend_rt_q;
      pend_pc_d    = pend_pc_q;
      if (ld_pending_d) begin
         pend_rt_d = bus.ld_rt;
         pend_pc_d = bus.ld_pc;
      end
   end

   // Pending load slot
   always_ff @(posedge clk) begin
      if (!resetn) begin
         ld_pending_q <= 1'b0;
         pend_rt_q    <= '0;
         pend_pc_q    <= '0;
      end else begin
         ld_pending_q <= ld_pending_d;
         pend_rt_q    <= pend_rt_d;
         pend_pc_q    <= pend_pc_d;
      end
   end

   // Register array; the younger ALU write lands after the load so it wins
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else begin
         if (ld_pending_q) regs_q[pend_rt_q]     <= bus.mem_rdata;
         if (alu_commit)   regs_q[bus.alu_waddr] <= bus.alu_wdata;
      end
   end

   // Read ports: r0, then returning load data, then the array
   always_comb begin
      bus.rd_data = '0;
      for (int k = 0; k < NRD; k++) begin
         if (bus.rd_addr[k*AW +: AW] == AW'(ZERO_REG))
            bus.rd_data[k*XLEN +: XLEN] = '0;
         else if (ld_pending_q && (bus.rd_addr[k*AW +: AW] == pend_rt_q))
            bus.rd_data[k*XLEN +: XLEN] = bus.mem_rdata;
         else
            bus.rd_data[k*XLEN +: XLEN] = regs_q[bus.rd_addr[k*AW +: AW]];
      end
   end

   trace_fifo #(
      .TDEPTH  (TDEPTH),
      .entry_t (entry_t)
   ) u_trace (
      .clk          (clk),
      .resetn       (resetn),
      .push0_i      (ld_pending_q),
      .push0_data_i (ld_entry),
      .push1_i      (alu_commit),
      .push1_data_i (alu_entry),
      .out_valid_o  (trace_valid),
      .out_data_o   (trace_head),
      .ovf_o        (bus.trace_ovf)
   );

   // Debug trace output register, one entry per cycle
   always_ff @(posedge clk) begin
      if (!resetn) begin
         dbg_wen_q <= 1'b0;
         dbg_q     <= '0;
      end else begin
         dbg_wen_q <= trace_valid;
         dbg_q     <= trace_valid ? trace_head : '0;
      end
   end

   assign bus.ld_pending        = ld_pending_q;
   assign bus.debug_wb_rf_wen   = dbg_wen_q;
   assign bus.debug_wb_pc       = dbg_q.pc;
   assign bus.debug_wb_rf_wnum  = dbg_q.wnum;
   assign bus.debug_wb_rf_wdata = dbg_q.wdata;

endmodule

// File: tb/tb_regfile_wb.sv
module tb_regfile_wb;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   n_pass = 0;
   int   n_total = 0;

   always #5 clk = ~clk;

   regfile_wb_if #(.XLEN(32), .NREG(32), .NRD(3)) bus ();

   regfile_wb #(.XLEN(32), .NREG(32), .NRD(3), .TDEPTH(2)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   typedef struct {
      logic        aw;  logic [4:0] awa; logic [31:0] awd; logic [31:0] apc;
      logic        li;  logic [4:0] lrt; logic [31:0] lpc; logic [31:0] mrd;
      logic [4:0]  r0;  logic [4:0] r1;  logic [4:0]  r2;
      logic [31:0] x0;  logic [31:0] x1; logic [31:0] x2;
      logic        ep;  logic ew; logic [31:0] epc; logic [4:0] ewn; logic [31:0] ewd;
   } vec_t;

   typedef struct {
      logic [31:0] pc; logic [4:0] wn; logic [31:0] wd;
   } ent_t;

   vec_t vecs[$];
   ent_t obs[$];
   ent_t expq[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic add(input logic aw, input logic [4:0] awa, input logic [31:0] awd, input logic [31:0] apc,
                      input logic li, input logic [4:0] lrt, input logic [31:0] lpc, input logic [31:0] mrd,
                      input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [31:0] x0, input logic [31:0] x1, input logic [31:0] x2,
                      input logic ep, input logic ew, input logic [31:0] epc, input logic [4:0] ewn, input logic [31:0] ewd);
      vec_t v;
      v.aw = aw; v.awa = awa; v.awd = awd; v.apc = apc;
      v.li = li; v.lrt = lrt; v.lpc = lpc; v.mrd = mrd;
      v.r0 = r0; v.r1 = r1; v.r2 = r2; v.x0 = x0; v.x1 = x1; v.x2 = x2;
      v.ep = ep; v.ew = ew; v.epc = epc; v.ewn = ewn; v.ewd = ewd;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic aw, input logic [4:0] awa, input logic [31:0] awd, input logic [31:0] apc,
                        input logic li, input logic [4:0] lrt, input logic [31:0] lpc, input logic [31:0] mrd);
      bus.alu_we = aw; bus.alu_waddr = awa; bus.alu_wdata = awd; bus.alu_pc = apc;
      bus.ld_issue = li; bus.ld_rt = lrt; bus.ld_pc = lpc; bus.mem_rdata = mrd;
   endtask

   task automatic tick_collect();
      ent_t e;
      @(posedge clk);
      #1;
      if (bus.debug_wb_rf_wen === 1'b1) begin
         e.pc = bus.debug_wb_pc; e.wn = bus.debug_wb_rf_wnum; e.wd = bus.debug_wb_rf_wdata;
         obs.push_back(e);
      end
   endtask

   task automatic push_exp(input logic [31:0] pc, input logic [4:0] wn, input logic [31:0] wd);
      ent_t e;
      e.pc = pc; e.wn = wn; e.wd = wd;
      expq.push_back(e);
   endtask

   task automatic compare_trace(input string tag);
      check($sformatf("%s trace count", tag), 64'(obs.size()), 64'(expq.size()));
      for (int j = 0; j < expq.size() && j < obs.size(); j++) begin
         check($sformatf("%s entry%0d pc", tag, j), 64'(obs[j].pc), 64'(expq[j].pc));
         check($sformatf("%s entry%0d wnum", tag, j), 64'(obs[j].wn), 64'(expq[j].wn));
         check($sformatf("%s entry%0d wdata", tag, j), 64'(obs[j].wd), 64'(expq[j].wd));
      end
   endtask

   initial begin
      // aw awa awd apc | li lrt lpc mrd | r0 r1 r2 | x0 x1 x2 | ep ew epc ewn ewd
      add(1, 5, 32'h1234, 32'h40,  0, 0, 0, 0,           5, 0, 1,  0, 0, 0,                             0, 0, 0, 0, 0);
      add(0, 0, 0, 0,              0, 0, 0, 0,           5, 5, 5,  32'h1234, 32'h1234, 32'h1234,        0, 1, 32'h40, 5, 32'h1234);
      add(0, 0, 0, 0,              1, 3, 32'h44, 0,      3, 5, 0,  0, 32'h1234, 0,                      0, 0, 0, 0, 0);
      add(0, 0, 0, 0,              0, 0, 0, 32'hCAFE,    3, 3, 5,  32'hCAFE, 32'hCAFE, 32'h1234,        1, 0, 0, 0, 0);
      add(0, 0, 0, 0,              0, 0, 0, 32'hDEAD,    3, 3, 3,  32'hCAFE, 32'hCAFE, 32'hCAFE,        0, 1, 32'h44, 3, 32'hCAFE);
      add(0, 0, 0, 0,              1, 3, 32'h48, 0,      3, 0, 5,  32'hCAFE, 0, 32'h1234,               0, 0, 0, 0, 0);
      add(1, 3, 32'h7, 32'h4C,     0, 0, 0, 32'hBEEF,    3, 5, 3,  32'hBEEF, 32'h1234, 32'hBEEF,        1, 0, 0, 0, 0);
      add(0, 0, 0, 0,              0, 0, 0, 0,           3, 3, 3,  32'h7, 32'h7, 32'h7,                 0, 1, 32'h48, 3, 32'hBEEF);
      add(0, 0, 0, 0,              0, 0, 0, 0,           3, 0, 5,  32'h7, 0, 32'h1234,                  0, 1, 32'h4C, 3, 32'h7);
      add(0, 0, 0, 0,              0, 0, 0, 0,           3, 3, 3,  32'h7, 32'h7, 32'h7,                 0, 0, 0, 0, 0);
      add(1, 0, 32'h55, 32'h50,    1, 0, 32'h54, 0,      0, 0, 0,  0, 0, 0,                             0, 0, 0, 0, 0);
      add(0, 0, 0, 0,              0, 0, 0, 32'h99,      0, 3, 5,  0, 32'h7, 32'h1234,                  0, 0, 0, 0, 0);
      add(0, 0, 0, 0,              0, 0, 0, 0,           0, 0, 0,  0, 0, 0,                             0, 0, 0, 0, 0);
      add(0, 0, 0, 0,              1, 7, 32'h60, 0,      7, 5, 3,  0, 32'h1234, 32'h7,                  0, 0, 0, 0, 0);
      add(0, 0, 0, 0,              1, 8, 32'h64, 32'h700, 7, 8, 5, 32'h700, 0, 32'h1234,                1, 0, 0, 0, 0);
      add(0, 0, 0, 0,              0, 0, 0, 32'h800,     7, 8, 0,  32'h700, 32'h800, 0,                 1, 1, 32'h60, 7, 32'h700);
      add(0, 0, 0, 0,              0, 0, 0, 32'h5555,    8, 7, 5,  32'h800, 32'h700, 32'h1234,          0, 1, 32'h64, 8, 32'h800);
      add(0, 0, 0, 0,              0, 0, 0, 0,           0, 0, 0,  0, 0, 0,                             0, 0, 0, 0, 0);

      // reset state
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      bus.rd_addr = {5'd31, 5'd2, 5'd1};
      resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset ld_pending", 64'(bus.ld_pending), 0);
      check("reset wen", 64'(bus.debug_wb_rf_wen), 0);
      check("reset pc", 64'(bus.debug_wb_pc), 0);
      check("reset wdata", 64'(bus.debug_wb_rf_wdata), 0);
      check("reset ovf", 64'(bus.trace_ovf), 0);
      check("reset rd_data", 64'(bus.rd_data), 0);
      resetn = 1'b1;

      // directed vector table, one row per cycle
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].aw, vecs[i].awa, vecs[i].awd, vecs[i].apc, vecs[i].li, vecs[i].lrt, vecs[i].lpc, vecs[i].mrd);
         bus.rd_addr = {vecs[i].r2, vecs[i].r1, vecs[i].r0};
         #1;
         check($sformatf("row%0d rd0", i), 64'(bus.rd_data[31:0]), 64'(vecs[i].x0));
         check($sformatf("row%0d rd1", i), 64'(bus.rd_data[63:32]), 64'(vecs[i].x1));
         check($sformatf("row%0d rd2", i), 64'(bus.rd_data[95:64]), 64'(vecs[i].x2));
         check($sformatf("row%0d ld_pending", i), 64'(bus.ld_pending), 64'(vecs[i].ep));
         check($sformatf("row%0d wen", i), 64'(bus.debug_wb_rf_wen), 64'(vecs[i].ew));
         if (vecs[i].ew) begin
            check($sformatf("row%0d trace pc", i), 64'(bus.debug_wb_pc), 64'(vecs[i].epc));
            check($sformatf("row%0d trace wnum", i), 64'(bus.debug_wb_rf_wnum), 64'(vecs[i].ewn));
            check($sformatf("row%0d trace wdata", i), 64'(bus.debug_wb_rf_wdata), 64'(vecs[i].ewd));
         end
         @(posedge clk);
         #1;
      end

      // alternating load / ALU stream of 20 instructions
      obs.delete();
      expq.delete();
      for (int i = 0; i < 20; i += 2) begin
         push_exp(32'h100 + 32'(4 * i), 5'(1 + i / 2), 32'h1000 + 32'(i));
         push_exp(32'h100 + 32'(4 * (i + 1)), 5'(16 + i / 2), 32'h2000 + 32'(i + 1));
         drive(0, 0, 0, 0, 1, 5'(1 + i / 2), 32'h100 + 32'(4 * i), 0);
         tick_collect();
         drive(1, 5'(16 + i / 2), 32'h2000 + 32'(i + 1), 32'h100 + 32'(4 * (i + 1)), 0, 0, 0, 32'h1000 + 32'(i));
         tick_collect();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) tick_collect();
      compare_trace("stream");
      check("stream ovf", 64'(bus.trace_ovf), 0);

      // sustained dual commits overflow a depth-2 queue
      obs.delete();
      expq.delete();
      push_exp(32'h200, 12, 32'hA0);
      push_exp(32'h204, 13, 32'hA1);
      push_exp(32'h208, 12, 32'hB0);
      push_exp(32'h20C, 13, 32'hB1);
      push_exp(32'h210, 12, 32'hC0);
      drive(0, 0, 0, 0, 1, 12, 32'h200, 0);
      tick_collect();
      drive(1, 13, 32'hA1, 32'h204, 1, 12, 32'h208, 32'hA0);
      tick_collect();
      drive(1, 13, 32'hB1, 32'h20C, 1, 12, 32'h210, 32'hB0);
      tick_collect();
      check("ovf before third dual", 64'(bus.trace_ovf), 0);
      drive(1, 13, 32'hC1, 32'h214, 0, 0, 0, 32'hC0);
      tick_collect();
      check("ovf after third dual", 64'(bus.trace_ovf), 1);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      bus.rd_addr = {5'd0, 5'd13, 5'd12};
      repeat (4) tick_collect();
      compare_trace("ovf");
      check("ovf sticky", 64'(bus.trace_ovf), 1);
      check("ovf r12", 64'(bus.rd_data[31:0]), 32'hC0);
      check("ovf r13", 64'(bus.rd_data[63:32]), 32'hC1);

      // reset in the middle of a load, then normal operation on release
      drive(0, 0, 0, 0, 1, 4, 32'h300, 0);
      resetn = 1'b0;
      @(posedge clk);
      #1;
      resetn = 1'b1;
      drive(1, 6, 32'h66, 32'h310, 0, 0, 0, 32'h777);
      bus.rd_addr = {5'd5, 5'd13, 5'd4};
      #1;
      check("rst ld_pending", 64'(bus.ld_pending), 0);
      check("rst r4 no bypass", 64'(bus.rd_data[31:0]), 0);
      check("rst r13 cleared", 64'(bus.rd_data[63:32]), 0);
      check("rst r5 cleared", 64'(bus.rd_data[95:64]), 0);
      check("rst ovf cleared", 64'(bus.trace_ovf), 0);
      check("rst wen", 64'(bus.debug_wb_rf_wen), 0);
      check("rst trace pc", 64'(bus.debug_wb_pc), 0);
      @(posedge clk);
      #1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      bus.rd_addr = {5'd0, 5'd6, 5'd4};
      #1;
      check("post-rst r4", 64'(bus.rd_data[31:0]), 0);
      check("post-rst r6", 64'(bus.rd_data[63:32]), 32'h66);
      check("post-rst wen", 64'(bus.debug_wb_rf_wen), 1);
      check("post-rst trace pc", 64'(bus.debug_wb_pc), 32'h310);
      check("post-rst trace wnum", 64'(bus.debug_wb_rf_wnum), 6);
      @(posedge clk);
      #1;
      check("post-rst single cycle", 64'(bus.debug_wb_rf_wen), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
